// File: rtl/recv_pkg.sv
// Shared types and constants for the receiver-port scheduler.
package recv_pkg;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_ABORT = 2'd3
  } sched_state_t;

  // Completion status reported with done.
  typedef enum logic [1:0] {
    SUCCESS = 2'd0,
    ERROR   = 2'd1,
    TIMEOUT = 2'd2,
    DROPPED = 2'd3
  } sched_status_t;

  // Codes the receiver emits on its out/vld stream when a frame terminates.
  localparam logic [7:0] RX_ERR_CODE = 8'hF9;
  localparam logic [7:0] RX_OK_CODE  = 8'h00;

  // Classify a frame that ended with the receiver returning to ready.
  // No valid byte in the last busy cycle means the receiver silently dropped
  // the frame (destination MAC mismatch). An unknown terminal code is treated
  // as an error so it is never reported as a good frame.
  function automatic sched_status_t classify_end(input logic       last_vld,
                                                 input logic [7:0] last_out);
    sched_status_t st;
    if (!last_vld)                  st = DROPPED;
    else if (last_out == RX_OK_CODE) st = SUCCESS;
    else                            st = ERROR;
    return st;
  endfunction

endpackage

// File: rtl/recv_port_sched_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// scanning upward modulo NUM_PORTS.
module rr_pick
  import recv_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         i_req,
  input  logic [$clog2(NUM_PORTS)-1:0] i_ptr,
  output logic [NUM_PORTS-1:0]         o_gnt,
  output logic [$clog2(NUM_PORTS)-1:0] o_gnt_idx,
  output logic                         o_any
);

  localparam int IW = $clog2(NUM_PORTS);

  logic [2*NUM_PORTS-1:0] w_dbl;
  logic [NUM_PORTS-1:0]   w_rot;
  logic [IW-1:0]          w_off;
  logic [IW:0]            w_sum;

  // Rotate requests so bit 0 corresponds to the port at i_ptr.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NUM_PORTS-1:0];

  // Offset of the lowest set bit; scanning downward leaves the lowest winning.
  always_comb begin
    w_off = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  // Undo the rotation; NUM_PORTS need not be a power of two.
  always_comb begin
    w_sum     = {1'b0, i_ptr} + {1'b0, w_off};
    o_gnt_idx = (w_sum >= (IW+1)'(NUM_PORTS)) ? IW'(w_sum - (IW+1)'(NUM_PORTS))
                                              : w_sum[IW-1:0];
  end

  assign o_any = |i_req;

  // One-hot grant, zero when nobody requests.
  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      o_gnt[i] = o_any && (o_gnt_idx == IW'(i));
    end
  end

endmodule

// File: rtl/recv_port_sched.sv
// Round-robin scheduler sharing one frame receiver between NUM_PORTS ports.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no grant; pick a requester once the receiver is ready
// ST_START | grant held, rx_start pulsed, receiver samples preamble byte 0
// ST_BUSY  | frame in flight; watchdog counting, last vld/out tracked
// ST_ABORT | watchdog expired; receiver held in reset for one cycle
module recv_port_sched
  import recv_pkg::*;
#(
  parameter int          NUM_PORTS      = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2048
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_PORTS-1:0]         i_port_req,
  input  logic [NUM_PORTS*8-1:0]       i_port_data,
  output logic [NUM_PORTS-1:0]         o_port_grant,
  output logic                         o_rx_start,
  output logic [7:0]                   o_rx_data,
  output logic                         o_rx_rst,
  input  logic                         i_rx_ready,
  input  logic                         i_rx_vld,
  input  logic [7:0]                   i_rx_out,
  output logic                         o_done,
  output logic [$clog2(NUM_PORTS)-1:0] o_done_port,
  output logic [1:0]                   o_done_status
);

  localparam int IW = $clog2(NUM_PORTS);

  sched_state_t   r_state;
  sched_state_t   w_state_next;
  logic [NUM_PORTS-1:0] r_grant;
  logic [IW-1:0]  r_gnt_idx;
  logic [IW-1:0]  r_ptr;
  logic [15:0]    r_cnt;
  logic           r_last_vld;
  logic [7:0]     r_last_out;
  logic           r_done;
  logic [IW-1:0]  r_done_port;
  logic [1:0]     r_done_status;

  logic [NUM_PORTS-1:0] w_pick_gnt;
  logic [IW-1:0]  w_pick_idx;
  logic           w_pick_any;
  logic           w_take;
  logic           w_frame_end;
  logic           w_abort;
  logic           w_complete;
  logic           w_tmo_hit;
  logic [IW-1:0]  w_ptr_next;
  sched_status_t  w_end_status;
  logic [7:0]     w_rx_data;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .i_req     (i_port_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_pick_gnt),
    .o_gnt_idx (w_pick_idx),
    .o_any     (w_pick_any)
  );

  assign w_take       = (r_state == ST_IDLE) && i_rx_ready && w_pick_any;
  assign w_frame_end  = (r_state == ST_BUSY) && i_rx_ready;
  assign w_abort      = (r_state == ST_ABORT);
  assign w_complete   = w_frame_end || w_abort;
  assign w_tmo_hit    = (r_cnt == TIMEOUT_CYCLES - 16'd1);
  assign w_ptr_next   = (r_gnt_idx == IW'(NUM_PORTS - 1)) ? '0 : r_gnt_idx + IW'(1);
  assign w_end_status = classify_end(r_last_vld, r_last_out);

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_take) w_state_next = ST_START;
      ST_START: w_state_next = ST_BUSY;
      ST_BUSY: begin
        if (i_rx_ready)     w_state_next = ST_IDLE;
        else if (w_tmo_hit) w_state_next = ST_ABORT;
      end
      ST_ABORT: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Grant latches at pick time and clears on the edge that raises done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant   <= '0;
      r_gnt_idx <= '0;
    end else if (w_take) begin
      r_grant   <= w_pick_gnt;
      r_gnt_idx <= w_pick_idx;
    end else if (w_complete) begin
      r_grant   <= '0;
    end
  end

  // Watchdog: cleared in START, counts every BUSY cycle that does not end.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_cnt <= '0;
    end else if ((r_state == ST_BUSY) && !i_rx_ready && !w_tmo_hit) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Track the receiver's last out/vld; START clears them so a frame that ends
  // immediately is not classified with the previous frame's terminal byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_vld <= 1'b0;
      r_last_out <= '0;
    end else if (r_state == ST_START) begin
      r_last_vld <= 1'b0;
      r_last_out <= '0;
    end else if (r_state == ST_BUSY) begin
      r_last_vld <= i_rx_vld;
      r_last_out <= i_rx_out;
    end
  end

  // Completion report: done pulses one cycle, port/status hold until the next.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done        <= 1'b0;
      r_done_port   <= '0;
      r_done_status <= '0;
    end else begin
      r_done <= w_complete;
      if (w_complete) begin
        r_done_port   <= r_gnt_idx;
        r_done_status <= w_abort ? TIMEOUT : w_end_status;
      end
    end
  end

  // Round-robin pointer advances past the port that just completed.
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_ptr <= '0;
    else if (w_complete) r_ptr <= w_ptr_next;
  end

  // Byte mux from the registered grant; zero while nobody owns the receiver.
  always_comb begin
    w_rx_data = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[i]) w_rx_data = i_port_data[i*8 +: 8];
    end
  end

  assign o_port_grant  = r_grant;
  assign o_rx_start    = (r_state == ST_START);
  assign o_rx_data     = w_rx_data;
  assign o_rx_rst      = i_rst || (r_state == ST_ABORT);
  assign o_done        = r_done;
  assign o_done_port   = r_done_port;
  assign o_done_status = r_done_status;

endmodule
